dense_layer_engine: RTL
=======================

# dense_layer_engine

Neuron-serial multiply-accumulate engine for one fully connected layer of the MNIST network. It is the direct consumer of the AXI4-Lite bias/control register block:
- its bias bus is driven from that block's bias registers;
- its start input is that block's control output;
- its done flag drives that block's status input.

It consumes a stream of (activation, weight) pairs and emits one biased, optionally rectified, 32-bit result per neuron.

## Interface
- N_NEURONS, 18, neurons per layer run (1..32)
- N_INPUTS, 784, input pairs per neuron (1..65535)
- DATA_W, 8, signed activation/weight width
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- start  in  1  level; a rising edge launches one layer run
- bias_flat  in  32*N_NEURONS  signed biases; neuron n at [32n+31:32n]
- s_valid  in  1  input pair valid
- s_ready  out  1  engine accepts pair
- s_act  in  DATA_W  signed activation
- s_wgt  in  DATA_W  signed weight
- m_valid  out  1  result valid
- m_ready  in  1  result accepted
- m_data  out  32  signed result
- m_idx  out  5  neuron index of m_data
- busy  out  1  high from launch until DONE
- done  out  1  sticky completion flag (status)

## Operation
- States: IDLE, ACCUM, BIAS, OUTPUT, DONE.
- start_q registers start. A launch is start & ~start_q, and is honoured only in IDLE or DONE.
  - Launch action: acc=0, n=0, k=0, done=0 → ACCUM.
  - A start edge in ACCUM/BIAS/OUTPUT is ignored.
- ACCUM:
  - s_ready=1.
  - Each s_valid&s_ready beat: acc += sext32(s_act*s_wgt), where the product is a full 2*DATA_W signed value; k++.
  - The beat with k==N_INPUTS-1 moves to BIAS.
- BIAS (1 cycle):
  - res = acc + bias_flat[n], 32-bit two's-complement wraparound.
  - Then the activation of Configuration; result registered into m_data; m_idx=n → OUTPUT.
- OUTPUT:
  - m_valid=1. m_data and m_idx are held stable until m_valid&m_ready.
  - On handshake: if n==N_NEURONS-1 → DONE; else n++, acc=0, k=0 → ACCUM.
- DONE: done=1, busy=0. Stays here until the next launch.
- The accumulator wraps mod 2^32; no saturation anywhere.
- bias_flat is sampled live in the BIAS cycle. Software must not rewrite biases while busy; doing so is defined behaviour but is not guaranteed to be coherent across neurons.

## Timing
- Reset values: s_ready=0, m_valid=0, m_data=0, m_idx=0, busy=0, done=0, start_q=0, state=IDLE.
- Because start_q resets to 0, a start held high across reset release launches a run on the first clock after release.
- Launch edge t: busy=1 and s_ready=1 from t+1.
- Last pair accepted at edge t: BIAS during t+1, m_valid=1 from t+2.
- Result handshake at edge t (not last neuron): s_ready=1 from t+1. Per-neuron overhead is 2 idle cycles on the input stream.
- Last result handshake at edge t: done=1 and busy=0 from t+1.
- Backpressure: if m_ready stays low, the engine stays in OUTPUT indefinitely with s_ready=0.
- Reset assertion mid-run aborts immediately. All outputs go to reset values; a partial result is never emitted.

## Configuration
- DENSE_RELU_EN defined: the BIAS-stage result is max(res, 0); any negative value outputs 0.
- DENSE_RELU_EN undefined: res passes through unchanged, i.e. the raw logit for the output layer.

## Test plan
- N_NEURONS=2, N_INPUTS=3, all pairs (2,3), bias 10 and -5, m_ready=1 → m_data 28 (idx 0) then 13 (idx 1); done=1 one cycle after the second handshake.
- Pairs (-128,127)×3 with bias 0:
  - DENSE_RELU_EN defined → m_data 0;
  - undefined → m_data -48768.
- Hold m_ready=0 for 20 cycles in OUTPUT → m_valid, m_data and m_idx stable; s_ready=0 throughout; the run completes normally after release.
- Toggle start during ACCUM → no restart; result values unchanged. A later start edge in DONE → done=0 and a new run produces identical results.
- Accumulate to 0x7FFFFFF0 and add bias 0x20 without ReLU → m_data 0x80000010 (wraparound).
- Assert aresetn=0 mid-neuron → all outputs 0 immediately. Next launch produces correct results from neuron 0.

Source files
------------

// File: rtl/dense_layer_engine.sv
// dense_layer_engine: neuron-serial MAC engine for one fully connected layer.
// Consumes (activation, weight) pairs, adds the per-neuron bias and emits one
// 32-bit result per neuron on a valid/ready stream.
// Optional feature macro: DENSE_RELU_EN (when defined, the biased result is
// rectified to max(res, 0); otherwise the raw logit is emitted).
module dense_layer_engine #(
  parameter int N_NEURONS = 18,
  parameter int N_INPUTS  = 784,
  parameter int DATA_W    = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          start,
  input  logic [32*N_NEURONS-1:0]       bias_flat,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic signed [DATA_W-1:0]      s_act,
  input  logic signed [DATA_W-1:0]      s_wgt,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [31:0]                   m_data,
  output logic [4:0]                    m_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int         PROD_W = 2 * DATA_W;
  localparam logic [15:0] K_LAST = 16'(N_INPUTS - 1);
  localparam logic [4:0]  N_LAST = 5'(N_NEURONS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    BIAS   = 3'd2,
    OUTPUT = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e       state_q, state_d;
  logic         start_q;
  logic [31:0]  acc_q, acc_d;
  logic [15:0]  k_q, k_d;
  logic [4:0]   n_q, n_d;
  logic [31:0]  m_data_q, m_data_d;
  logic [4:0]   m_idx_q, m_idx_d;

  logic                     launch;
  logic signed [PROD_W-1:0] prod;
  logic signed [31:0]       prod_ext;
  logic [31:0]              bias_sel;
  logic [31:0]              res;
  logic [31:0]              res_act;

  // Rising edge of the level start input; only honoured in IDLE/DONE below.
  assign launch   = start & ~start_q;

  // Full-width signed product, sign-extended into the 32-bit accumulator.
  assign prod     = s_act * s_wgt;
  assign prod_ext = 32'(prod);

  // Bias is sampled live for the neuron being finished.
  assign bias_sel = bias_flat[32*int'(n_q) +: 32];
  assign res      = acc_q + bias_sel;

`ifdef DENSE_RELU_EN
  assign res_act  = res[31] ? 32'd0 : res;
`else
  assign res_act  = res;
`endif

  // Next-state and datapath update for the run sequencer.
  always_comb begin
    // NOTE: every _d gets a hold default first so no latch is inferred on paths that don't assign it.
    state_d  = state_q;
    acc_d    = acc_q;
    k_d      = k_q;
    n_d      = n_q;
    m_data_d = m_data_q;
    m_idx_d  = m_idx_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (launch) begin
          acc_d   = '0;
          k_d     = '0;
          n_d     = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (s_valid) begin
          acc_d = acc_q + prod_ext;
          k_d   = k_q + 16'd1;
          if (k_q == K_LAST) state_d = BIAS;
        end
      end
      BIAS: begin
        m_data_d = res_act;
        m_idx_d  = n_q;
        state_d  = OUTPUT;
      end
      OUTPUT: begin
        if (m_ready) begin
          if (n_q == N_LAST) begin
            state_d = DONE;
          end else begin
            n_d     = n_q + 5'd1;
            acc_d   = '0;
            k_d     = '0;
            state_d = ACCUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      acc_q    <= '0;
      k_q      <= '0;
      n_q      <= '0;
      m_data_q <= '0;
      m_idx_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values together.
      state_q  <= state_d;
      start_q  <= start;
      acc_q    <= acc_d;
      k_q      <= k_d;
      n_q      <= n_d;
      m_data_q <= m_data_d;
      m_idx_q  <= m_idx_d;
    end
  end

  assign s_ready = (state_q == ACCUM);
  assign m_valid = (state_q == OUTPUT);
  assign busy    = (state_q == ACCUM) || (state_q == BIAS) || (state_q == OUTPUT);
  assign done    = (state_q == DONE);
  assign m_data  = m_data_q;
  assign m_idx   = m_idx_q;

endmodule
